// File: rtl/cic_strobe_gen_pkg.sv
// Shared DSP definitions for the CIC decimation chain: default ratio limit and
// rate-bounds helpers used by both the strobe generator and the decimator.
package cic_strobe_gen_pkg;

    localparam int unsigned DEFAULT_MAXRATE = 64;

    // Legal decimation ratios are 1..maxrate; out-of-range requests saturate.
    function automatic int unsigned clamp_rate(input int unsigned rate, input int unsigned maxrate);
        if (rate == 0) begin
            return 1;
        end else if (rate > maxrate) begin
            return maxrate;
        end
        return rate;
    endfunction

    function automatic logic rate_out_of_range(input int unsigned rate, input int unsigned maxrate);
        return (rate == 0) || (rate > maxrate);
    endfunction

endpackage

// File: rtl/cic_strobe_gen.sv
// Decimation-strobe generator: counts qualified input samples and emits a
// one-cycle output-rate strobe every R samples, with run-time R and phase sync.
module cic_strobe_gen
    import cic_strobe_gen_pkg::*;
#(
    parameter int unsigned MAXRATE    = DEFAULT_MAXRATE,
    parameter int unsigned RATE_WIDTH = $clog2(MAXRATE) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  ce_i,
    input  logic [RATE_WIDTH-1:0] rate_i,
    input  logic                  sync_i,
    input  logic                  sync_en_i,
    output logic                  ce_o,
    output logic                  strobe_o,
    output logic [RATE_WIDTH-1:0] phase_o,
    output logic [RATE_WIDTH-1:0] rate_o,
    output logic                  sync_done_o,
    output logic                  rate_err_o
);

    localparam logic [RATE_WIDTH-1:0] MAXRATE_W = RATE_WIDTH'(MAXRATE);
    localparam logic [RATE_WIDTH-1:0] ONE_W     = RATE_WIDTH'(1);

    logic                  q_c;
    logic                  sync_acc_c;
    logic                  wrap_c;
    logic                  rate_bad_c;
    logic [RATE_WIDTH-1:0] rate_clamped_c;

    assign q_c            = ce_i & en_i;
    assign sync_acc_c     = sync_i & sync_en_i & en_i;
    assign rate_clamped_c = RATE_WIDTH'(clamp_rate(32'(rate_i), MAXRATE));
    assign rate_bad_c     = rate_out_of_range(32'(rate_i), MAXRATE);
    assign wrap_c         = q_c && (phase_o == (rate_o - ONE_W));

    // phase_o and rate_o are the count and effective ratio registers themselves.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ce_o        <= 1'b0;
            strobe_o    <= 1'b0;
            phase_o     <= '0;
            rate_o      <= MAXRATE_W;
            sync_done_o <= 1'b0;
            rate_err_o  <= 1'b0;
        end else begin
            ce_o        <= q_c;
            sync_done_o <= sync_acc_c;
            strobe_o    <= 1'b0;
            if (sync_acc_c) begin
                // Sync wins over a coincident wrap; a coincident sample is index 0.
                rate_o     <= rate_clamped_c;
                rate_err_o <= rate_err_o | rate_bad_c;
                if (q_c && (rate_clamped_c == ONE_W)) begin
                    strobe_o <= 1'b1;
                    phase_o  <= '0;
                end else if (q_c) begin
                    phase_o  <= ONE_W;
                end else begin
                    phase_o  <= '0;
                end
            end else if (wrap_c) begin
                strobe_o   <= 1'b1;
                phase_o    <= '0;
                rate_o     <= rate_clamped_c;
                rate_err_o <= rate_err_o | rate_bad_c;
            end else if (q_c) begin
                phase_o    <= phase_o + ONE_W;
            end
        end
    end

endmodule
